// File: rtl/banked_sram_pkg.sv
// Shared types and address-map helpers for the banked multi-read SRAM.
// Bank index is the low-order address field; the row is everything above it.
package banked_sram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   function automatic int lb_of(input int num_banks);
      return $clog2(num_banks);
   endfunction

   function automatic int row_w_of(input int addr_w, input int num_banks);
      return addr_w - $clog2(num_banks);
   endfunction

   function automatic int unsigned bank_of(input logic [31:0] addr, input int num_banks);
      return addr & 32'(num_banks - 1);
   endfunction

   function automatic int unsigned row_of(input logic [31:0] addr, input int num_banks);
      return addr >> $clog2(num_banks);
   endfunction

endpackage

// File: rtl/sram_bank.sv
// One 1R1W storage bank with a registered, enable-gated read port.
module sram_bank #(
   parameter int DATA_W = 72,
   parameter int ROW_W  = 5
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ROW_W-1:0]  rd_row,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ROW_W];

   // NOTE: the array and read register have no reset so the bank can map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_row] <= wr_data;
      if (rd_en) rd_data <= mem[rd_row];
   end

endmodule

// File: rtl/banked_nread_sram.sv
// NUM_RD-lane read front end over NUM_BANKS interleaved banks; conflicting
// lanes are serialised one round per cycle, same-row lanes share a bank read.
module banked_nread_sram
   import banked_sram_pkg::*;
#(
   parameter int DATA_W    = 72,
   parameter int ADDR_W    = 8,
   parameter int NUM_BANKS = 8,
   parameter int NUM_RD    = 4,
   parameter int CNT_W     = 4
) (
   input  logic                     i_fire,
   input  logic                     rst,
   input  logic                     i_rd_valid,
   output logic                     o_rd_ready,
   input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
   input  logic [NUM_RD-1:0]        i_rd_mask,
   input  logic                     i_wr_en,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic [DATA_W-1:0]        i_wr_data,
   output logic                     o_rsp_valid,
   output logic [NUM_RD*DATA_W-1:0] o_rsp_data,
   output logic [CNT_W-1:0]         o_rsp_rounds,
   output logic                     o_busy
);

   localparam int LB    = lb_of(NUM_BANKS);
   localparam int ROW_W = row_w_of(ADDR_W, NUM_BANKS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state_q;
   logic [NUM_RD-1:0]   pend_q, pend_cur, served, served_q;
   logic [ADDR_W-1:0]   addr_q [NUM_RD];
   logic [ADDR_W-1:0]   addr_cur [NUM_RD];
   logic [LB-1:0]       lane_bank [NUM_RD];
   logic [LB-1:0]       bank_q [NUM_RD];
   logic [ROW_W-1:0]    lane_row [NUM_RD];
   logic [LB-1:0]       wr_bank;
   logic [ROW_W-1:0]    wr_row;
   logic [NUM_BANKS-1:0] bank_rd_en, bank_wr_en;
   logic [ROW_W-1:0]    bank_rd_row [NUM_BANKS];
   logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];
   logic [DATA_W-1:0]   lane_live [NUM_RD];
   logic [DATA_W-1:0]   work_q [NUM_RD];
   logic [DATA_W-1:0]   hold_q [NUM_RD];
   logic                accept, active, done, rsp_valid_q;
   logic [CNT_W-1:0]    cnt_q, cnt_cur, rounds_q;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      accept     = i_rd_valid && (state_q == IDLE);
      active     = accept || (state_q == DRAIN);
      pend_cur   = accept ? i_rd_mask : pend_q;
      wr_bank    = LB'(bank_of(32'(i_wr_addr), NUM_BANKS));
      wr_row     = ROW_W'(row_of(32'(i_wr_addr), NUM_BANKS));
      bank_rd_en = '0;
      bank_wr_en = '0;
      served     = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_rd_row[b] = '0;
         bank_wr_en[b]  = i_wr_en && (wr_bank == LB'(b));
      end
      for (int k = 0; k < NUM_RD; k++) begin
         addr_cur[k]  = accept ? i_rd_addr[k*ADDR_W +: ADDR_W] : addr_q[k];
         lane_bank[k] = LB'(bank_of(32'(addr_cur[k]), NUM_BANKS));
         lane_row[k]  = ROW_W'(row_of(32'(addr_cur[k]), NUM_BANKS));
         lane_live[k] = served_q[k] ? bank_rdata[bank_q[k]] : work_q[k];
         o_rsp_data[k*DATA_W +: DATA_W] = rsp_valid_q ? lane_live[k] : hold_q[k];
      end
      // Walk lanes high to low so the lowest-index pending lane owns each bank's row.
      for (int k = NUM_RD - 1; k >= 0; k--) begin
         if (pend_cur[k] && !bank_wr_en[lane_bank[k]]) begin
            bank_rd_en[lane_bank[k]]  = 1'b1;
            bank_rd_row[lane_bank[k]] = lane_row[k];
         end
      end
      for (int k = 0; k < NUM_RD; k++) begin
         served[k] = pend_cur[k] && bank_rd_en[lane_bank[k]] &&
                     (bank_rd_row[lane_bank[k]] == lane_row[k]);
      end
      done    = active && ((pend_cur & ~served) == '0);
      cnt_cur = (state_q == IDLE) ? CNT_W'(1) :
                (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sram_bank #(
         .DATA_W(DATA_W),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk    (i_fire),
         .wr_en  (bank_wr_en[b]),
         .wr_row (wr_row),
         .wr_data(i_wr_data),
         .rd_en  (bank_rd_en[b]),
         .rd_row (bank_rd_row[b]),
         .rd_data(bank_rdata[b])
      );
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_fire) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         served_q    <= '0;
         rsp_valid_q <= 1'b0;
         cnt_q       <= '0;
         rounds_q    <= '0;
         for (int k = 0; k < NUM_RD; k++) begin
            work_q[k] <= '0;
            hold_q[k] <= '0;
         end
      end else begin
         served_q    <= served;
         rsp_valid_q <= done;
         for (int k = 0; k < NUM_RD; k++) begin
            bank_q[k] <= lane_bank[k];
            if (accept) begin
               addr_q[k] <= addr_cur[k];
               work_q[k] <= '0;
            end else if (served_q[k]) begin
               work_q[k] <= bank_rdata[bank_q[k]];
            end
            if (rsp_valid_q) hold_q[k] <= lane_live[k];
         end
         if (active) begin
            cnt_q   <= cnt_cur;
            pend_q  <= pend_cur & ~served;
            state_q <= done ? IDLE : DRAIN;
         end
         if (done) rounds_q <= cnt_cur;
      end
   end

   assign o_rd_ready   = (state_q == IDLE);
   assign o_busy       = (state_q == DRAIN);
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_rounds = rounds_q;

endmodule

// File: tb/tb_banked_nread_sram.sv
// Directed plus randomized checks of banked_nread_sram against a word-array
// model; round counts come from distinct addresses per bank.
module tb_banked_nread_sram;

   localparam int DATA_W    = 72;
   localparam int ADDR_W    = 8;
   localparam int NUM_BANKS = 8;
   localparam int NUM_RD    = 4;
   localparam int CNT_W     = 4;

   logic                     i_fire = 1'b0;
   logic                     rst;
   logic                     i_rd_valid;
   logic                     o_rd_ready;
   logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
   logic [NUM_RD-1:0]        i_rd_mask;
   logic                     i_wr_en;
   logic [ADDR_W-1:0]        i_wr_addr;
   logic [DATA_W-1:0]        i_wr_data;
   logic                     o_rsp_valid;
   logic [NUM_RD*DATA_W-1:0] o_rsp_data;
   logic [CNT_W-1:0]         o_rsp_rounds;
   logic                     o_busy;

   logic [DATA_W-1:0] model_mem [2**ADDR_W];
   int tests = 0;
   int fails = 0;

   always #5 i_fire = ~i_fire;

   banked_nread_sram #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS),
      .NUM_RD(NUM_RD), .CNT_W(CNT_W)
   ) dut (
      .i_fire      (i_fire),
      .rst         (rst),
      .i_rd_valid  (i_rd_valid),
      .o_rd_ready  (o_rd_ready),
      .i_rd_addr   (i_rd_addr),
      .i_rd_mask   (i_rd_mask),
      .i_wr_en     (i_wr_en),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_rounds(o_rsp_rounds),
      .o_busy      (o_busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] lane_addr(input logic [NUM_RD*ADDR_W-1:0] a, input int k);
      return a[k*ADDR_W +: ADDR_W];
   endfunction

   // A bank needs one round per distinct address aimed at it; a same-cycle write delays it by one.
   function automatic int exp_rounds(input logic [NUM_RD*ADDR_W-1:0] a, input logic [NUM_RD-1:0] m,
                                     input logic we, input logic [ADDR_W-1:0] wa);
      int r;
      r = 1;
      for (int b = 0; b < NUM_BANKS; b++) begin
         int n;
         n = 0;
         for (int k = 0; k < NUM_RD; k++) begin
            bit dup;
            dup = 0;
            for (int j = 0; j < k; j++)
               if (m[j] && lane_addr(a, j) == lane_addr(a, k)) dup = 1;
            if (m[k] && !dup && (int'(lane_addr(a, k)) % NUM_BANKS == b)) n++;
         end
         if (n > 0 && we && (int'(wa) % NUM_BANKS == b)) n++;
         if (n > r) r = n;
      end
      return r;
   endfunction

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
      model_mem[a] = d;
      @(posedge i_fire); #1;
      i_wr_en = 1'b0;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_req(input string tag, input logic [NUM_RD*ADDR_W-1:0] a,
                          input logic [NUM_RD-1:0] m, input logic we,
                          input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
      int er, lat;
      logic [DATA_W-1:0] exp_d [NUM_RD];
      check($sformatf("%s/ready_idle", tag), 128'(o_rd_ready), 128'(1));
      i_rd_valid = 1'b1; i_rd_addr = a; i_rd_mask = m;
      i_wr_en = we; i_wr_addr = wa; i_wr_data = wd;
      er = exp_rounds(a, m, we, wa);
      if (we) model_mem[wa] = wd;
      for (int k = 0; k < NUM_RD; k++) exp_d[k] = m[k] ? model_mem[lane_addr(a, k)] : '0;
      @(posedge i_fire); #1;
      i_rd_valid = 1'b0; i_wr_en = 1'b0;
      check($sformatf("%s/busy", tag), 128'(o_busy), 128'(er > 1));
      check($sformatf("%s/ready_after", tag), 128'(o_rd_ready), 128'(er == 1));
      lat = 1;
      while (o_rsp_valid !== 1'b1 && lat < 32) begin
         @(posedge i_fire); #1;
         lat++;
      end
      check($sformatf("%s/valid", tag), 128'(o_rsp_valid), 128'(1));
      check($sformatf("%s/latency", tag), 128'(lat), 128'(er));
      check($sformatf("%s/rounds", tag), 128'(o_rsp_rounds), 128'(er));
      for (int k = 0; k < NUM_RD; k++)
         check($sformatf("%s/lane%0d", tag, k), 128'(o_rsp_data[k*DATA_W +: DATA_W]), 128'(exp_d[k]));
      @(posedge i_fire); #1;
      check($sformatf("%s/pulse", tag), 128'(o_rsp_valid), 128'(0));
      for (int k = 0; k < NUM_RD; k++)
         check($sformatf("%s/hold%0d", tag, k), 128'(o_rsp_data[k*DATA_W +: DATA_W]), 128'(exp_d[k]));
   endtask

   initial begin
      logic [NUM_RD*ADDR_W-1:0] ra;
      logic [NUM_RD*DATA_W-1:0] prev_exp;
      int lat;

      rst = 1'b1; i_rd_valid = 1'b0; i_rd_addr = '0; i_rd_mask = '0;
      i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      repeat (2) @(posedge i_fire);
      #1;
      check("rst/valid",  128'(o_rsp_valid),  128'(0));
      check("rst/data",   128'(o_rsp_data),   128'(0));
      check("rst/rounds", 128'(o_rsp_rounds), 128'(0));
      check("rst/busy",   128'(o_busy),       128'(0));
      check("rst/ready",  128'(o_rd_ready),   128'(1));
      rst = 1'b0;

      for (int a = 0; a < 2**ADDR_W; a++)
         do_write(ADDR_W'(a), {$urandom_range(255, 0), $urandom, $urandom});
      for (int a = 'h10; a <= 'h17; a++) do_write(ADDR_W'(a), DATA_W'(a * 3));

      run_req("t1_clean",     {8'h13, 8'h12, 8'h11, 8'h10}, 4'hF, 1'b0, '0, '0);
      run_req("t2_conflict",  {8'h28, 8'h20, 8'h18, 8'h10}, 4'hF, 1'b0, '0, '0);
      run_req("t3_broadcast", {8'h11, 8'h18, 8'h10, 8'h10}, 4'hF, 1'b0, '0, '0);
      run_req("t4_wr_prio",   {8'h00, 8'h00, 8'h00, 8'h13}, 4'h1, 1'b1, 8'h13, 72'hABC);
      run_req("t6_mask",      {8'h13, 8'h12, 8'h11, 8'h10}, 4'b0101, 1'b0, '0, '0);
      run_req("t6_empty",     {8'h13, 8'h12, 8'h11, 8'h10}, 4'b0000, 1'b0, '0, '0);

      // Reset in the middle of a four-round drain drops the request.
      i_rd_valid = 1'b1; i_rd_addr = {8'h28, 8'h20, 8'h18, 8'h10}; i_rd_mask = 4'hF;
      @(posedge i_fire); #1;
      i_rd_valid = 1'b0;
      check("t5/busy_before", 128'(o_busy), 128'(1));
      rst = 1'b1;
      @(posedge i_fire); #1;
      rst = 1'b0;
      check("t5/ready", 128'(o_rd_ready), 128'(1));
      check("t5/busy",  128'(o_busy),     128'(0));
      lat = 0;
      repeat (6) begin
         if (o_rsp_valid === 1'b1) lat++;
         @(posedge i_fire); #1;
      end
      check("t5/no_rsp", 128'(lat), 128'(0));
      run_req("t5_after", {8'h17, 8'h16, 8'h15, 8'h14}, 4'hF, 1'b0, '0, '0);

      // Back-to-back conflict-free requests, one accepted and answered every cycle.
      prev_exp = '0;
      for (int i = 0; i < 6; i++) begin
         logic [NUM_RD*DATA_W-1:0] cur_exp;
         for (int k = 0; k < NUM_RD; k++)
            ra[k*ADDR_W +: ADDR_W] = ADDR_W'(($urandom_range(31, 0) << 3) | (k * 2));
         for (int k = 0; k < NUM_RD; k++)
            cur_exp[k*DATA_W +: DATA_W] = model_mem[lane_addr(ra, k)];
         check($sformatf("b2b%0d/ready", i), 128'(o_rd_ready), 128'(1));
         if (i > 0) begin
            check($sformatf("b2b%0d/valid", i), 128'(o_rsp_valid), 128'(1));
            for (int k = 0; k < NUM_RD; k++)
               check($sformatf("b2b%0d/lane%0d", i, k), 128'(o_rsp_data[k*DATA_W +: DATA_W]),
                     128'(prev_exp[k*DATA_W +: DATA_W]));
         end
         i_rd_valid = 1'b1; i_rd_addr = ra; i_rd_mask = 4'hF;
         prev_exp = cur_exp;
         @(posedge i_fire); #1;
      end
      i_rd_valid = 1'b0;
      check("b2b_last/valid", 128'(o_rsp_valid), 128'(1));
      for (int k = 0; k < NUM_RD; k++)
         check($sformatf("b2b_last/lane%0d", k), 128'(o_rsp_data[k*DATA_W +: DATA_W]),
               128'(prev_exp[k*DATA_W +: DATA_W]));
      @(posedge i_fire); #1;

      // Randomized requests over a narrow address window to provoke conflicts and broadcasts.
      for (int i = 0; i < 60; i++) begin
         logic we;
         logic [ADDR_W-1:0] wa;
         if ($urandom_range(3, 0) == 0)
            do_write(ADDR_W'($urandom_range(63, 0)), {$urandom_range(255, 0), $urandom, $urandom});
         for (int k = 0; k < NUM_RD; k++)
            ra[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(63, 0));
         we = 1'($urandom_range(1, 0));
         wa = ADDR_W'($urandom_range(63, 0));
         run_req($sformatf("rnd%0d", i), ra, NUM_RD'($urandom_range(15, 0)), we, wa,
                 {$urandom_range(255, 0), $urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/banked_nread_sram.md
Name: banked_nread_sram

Overview:
Parametrised successor to the fixed four-way-read SRAM: NUM_RD read lanes and one write port over NUM_BANKS low-order-interleaved 1R1W banks. Bank conflicts are detected and serialised over multiple cycles with a valid/ready request handshake and a single-cycle response pulse. Same-row hits are broadcast, and writes take priority over reads on the same bank. Sits between the fetch/issue logic and the instruction/data store in the bProcess datapath.

Parameters:
DATA_W, 72, bits per word
ADDR_W, 8, word address width
NUM_BANKS, 8, bank count; power of two ≥2; LB = log2(NUM_BANKS)
NUM_RD, 4, read lanes per request
CNT_W, 4, width of o_rsp_rounds; saturating

Ports:
i_fire  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_rd_valid  in  1  read request valid
o_rd_ready  out  1  request accepted when valid&ready
i_rd_addr  in  NUM_RD*ADDR_W  lane k address at [k*ADDR_W +: ADDR_W]
i_rd_mask  in  NUM_RD  lane k active when bit k = 1
i_wr_en  in  1  write strobe; no handshake, always taken
i_wr_addr  in  ADDR_W  write word address
i_wr_data  in  DATA_W  write data
o_rsp_valid  out  1  one-cycle pulse; all lanes of the request are valid
o_rsp_data  out  NUM_RD*DATA_W  lane k at [k*DATA_W +: DATA_W]
o_rsp_rounds  out  CNT_W  bank-access rounds used by this request (saturating)
o_busy  out  1  request in service (DRAIN)

Behaviour:
- Clock is i_fire and reset is rst. Reset is synchronous and active-high.
- Address map: bank = addr[LB-1:0]; row = addr[ADDR_W-1:LB]; bank depth = 2^(ADDR_W-LB).
- Reset values: o_rsp_valid=0, o_rsp_data=0, o_rsp_rounds=0, o_busy=0, o_rd_ready=1, state IDLE, pending mask 0. Bank contents are not reset.
- States:
  - IDLE: o_rd_ready=1. On accept, pending = i_rd_mask; addresses and mask are latched; round 1 runs in the accept cycle.
  - DRAIN: o_rd_ready=0, o_busy=1. One round per cycle. Go to IDLE in the cycle whose round clears pending.
- Round (combinational select, registered bank read):
  - For each bank, the winner is the lowest-index pending lane targeting that bank.
  - Every pending lane with the same (bank,row) as the winner is also served (broadcast).
  - Served lanes leave pending. Their data is captured into lane result registers on the next edge.
- Write priority: if i_wr_en targets bank b in a cycle, bank b performs no read that cycle. Lanes targeting b stay pending.
- The write commits at the edge. A read of the same address in a later round returns the new data.
- Response timing:
  - o_rsp_valid pulses the cycle after the round that empties pending.
  - A conflict-free request accepted at cycle t responds at t+1.
  - A request needing R rounds responds at t+R.
  - Back-to-back conflict-free requests sustain one per cycle.
- o_rsp_data is held until the next response. Masked-off lanes read 0.
- Empty mask (i_rd_mask=0): accepted, zero rounds of bank access. Response at t+1 with all lanes 0, o_rsp_rounds=1.
- o_rsp_rounds counts cycles from accept to last round inclusive, saturating at 2^CNT_W-1.
- No starvation guard: upstream must not write the same bank every cycle while a read to it is pending.
- Reset mid-DRAIN: request dropped, no o_rsp_valid, o_rd_ready=1 in the cycle after reset.
- Simultaneous write + accepted request on different banks: both proceed, no extra round.

Decomposition:
- Package banked_sram_pkg: LB/row-width localparam functions, bank_of()/row_of() helpers, state enum {IDLE, DRAIN}.
- Sub-module sram_bank: 1R1W, DATA_W x 2^(ADDR_W-LB), registered read with read-enable. Instantiated NUM_BANKS times in a generate loop.
- Top keeps the lane arbiter, pending mask, FSM and result registers.

Test Plan:
1. Write addr 0x10..0x17 with data = addr*3. Read lanes {0x10,0x11,0x12,0x13}, mask 0xF, accepted at t → o_rsp_valid at t+1, lanes {0x30,0x33,0x36,0x39}, rounds=1.
2. Read {0x10,0x18,0x20,0x28} (all bank 0, different rows) → o_rd_ready low for 3 cycles, o_busy=1, response at t+4, rounds=4, lane data in lane order.
3. Read {0x10,0x10,0x18,0x11} → lanes 0/1 broadcast in round 1 and lane 2 deferred. Response at t+2, rounds=2, lanes 0,1 = 0x30.
4. Write 0x13 ← 0xABC in the same cycle a request for lane0=0x13 is accepted → bank 3 read deferred. Response at t+2 with lane0=0xABC, rounds=2.
5. Assert rst for 1 cycle during DRAIN of scenario 2 → no o_rsp_valid afterwards. o_rd_ready=1 and o_busy=0 the next cycle. A new conflict-free request responds normally.
6. Mask 4'b0101 with addresses {0x10,0x11,0x12,0x13} → lanes 1,3 = 0, lanes 0,2 = {0x30,0x36}, rounds=1. Mask 0 → response at t+1, all lanes 0.
